// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the two ports of a 128x8 true dual-port RAM among
// four requesters. After reset both ports clear the RAM to INIT_VAL, then up
// to two requests per cycle are granted in round-robin order, with same-address
// hazards between the two ports filtered out. Reads return one cycle later.
//
//   state  | meaning
//   S_INIT | clearing RAM, two words per cycle, no grants
//   S_RUN  | round-robin arbitration across both ports
module ram_port_arbiter #(
  parameter int            AW       = 7,
  parameter int            DW       = 8,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [3:0]      we,
  input  logic [4*AW-1:0] addr,
  input  logic [4*DW-1:0] wdata,
  output logic [3:0]      gnt,
  output logic [3:0]      rvalid,
  output logic [4*DW-1:0] rdata,
  output logic            init_done,
  output logic [AW-1:0]   ram_a1,
  output logic [AW-1:0]   ram_a2,
  output logic [DW-1:0]   ram_d1,
  output logic [DW-1:0]   ram_d2,
  output logic            ram_wr1,
  output logic            ram_wr2,
  input  logic [DW-1:0]   ram_q1,
  input  logic [DW-1:0]   ram_q2
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state_q;
  logic [AW-2:0]   c_q;
  logic [1:0]      ptr_q;
  logic            init_done_q;
  logic [3:0]      rv_q;
  logic [3:0]      sel_q;
  logic [AW-1:0]   a1_q, a2_q;
  logic [DW-1:0]   d1_q, d2_q;

  logic            found_a, found_b;
  logic [1:0]      idx_a, idx_b, j;
  logic [3:0]      rv_d, sel_d;
  logic [1:0]      ptr_d;

  // Round-robin scan from ptr: first requester takes port A, the next one
  // that does not collide with A's address (unless both are reads) takes B.
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    j       = '0;
    for (int k = 0; k < 4; k++) begin
      j = ptr_q + 2'(k);
      if (state_q == S_RUN && req[j]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = j;
        end else if (!found_b &&
                     ((addr[j*AW +: AW] != addr[idx_a*AW +: AW]) ||
                      (!we[j] && !we[idx_a]))) begin
          found_b = 1'b1;
          idx_b   = j;
        end
      end
    end
  end

  // Grant vector, read-return bookkeeping and next pointer.
  always_comb begin
    gnt   = '0;
    rv_d  = '0;
    sel_d = '0;
    ptr_d = ptr_q;
    if (found_a) begin
      gnt[idx_a] = 1'b1;
      rv_d[idx_a] = ~we[idx_a];
      ptr_d = idx_a + 2'd1;
    end
    if (found_b) begin
      gnt[idx_b] = 1'b1;
      rv_d[idx_b] = ~we[idx_b];
      sel_d[idx_b] = 1'b1;
      ptr_d = idx_b + 2'd1;
    end
  end

  // RAM port drive: clearing pattern in INIT, granted lanes or held values in RUN.
  // Write enables are forced low while rst is asserted.
  always_comb begin
    if (state_q == S_INIT) begin
      ram_a1  = {c_q, 1'b0};
      ram_a2  = {c_q, 1'b1};
      ram_d1  = INIT_VAL;
      ram_d2  = INIT_VAL;
      ram_wr1 = ~rst;
      ram_wr2 = ~rst;
    end else begin
      ram_a1  = found_a ? addr[idx_a*AW +: AW]  : a1_q;
      ram_d1  = found_a ? wdata[idx_a*DW +: DW] : d1_q;
      ram_wr1 = found_a & we[idx_a];
      ram_a2  = found_b ? addr[idx_b*AW +: AW]  : a2_q;
      ram_d2  = found_b ? wdata[idx_b*DW +: DW] : d2_q;
      ram_wr2 = found_b & we[idx_b];
    end
  end

  // Read data steering: each valid lane picks the port its read used.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (rv_q[i]) rdata[i*DW +: DW] = sel_q[i] ? ram_q2 : ram_q1;
    end
  end

  assign rvalid    = rv_q;
  assign init_done = init_done_q;

  // Sequencer: clear counter, round-robin pointer, read pipeline, held port values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      c_q         <= '0;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      rv_q        <= '0;
      sel_q       <= '0;
      a1_q        <= '0;
      a2_q        <= AW'(1);
      d1_q        <= INIT_VAL;
      d2_q        <= INIT_VAL;
    end else begin
      a1_q  <= ram_a1;
      a2_q  <= ram_a2;
      d1_q  <= ram_d1;
      d2_q  <= ram_d2;
      rv_q  <= rv_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      case (state_q)
        S_INIT: begin
          c_q <= c_q + 1'b1;
          if (c_q == '1) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_RUN;
        end
      endcase
    end
  end

endmodule
